ram_dp_port_ctrl: RTL and testbench

Command front-end for one port of the generic dual-port RAM (`ram_dp`). It accepts independent write and read command streams over valid/ready and arbitrates them onto the RAM port, one operation per cycle. Read data is returned through a credit-protected 2-entry response FIFO, so backpressure never loses RAM output. An optional clear sweep zeroes the whole memory after reset or on request.

---
 rtl/ram_dp_port_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_ram_dp_port_ctrl.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_dp_port_ctrl.sv
// Command front-end for one ram_dp port: write/read arbitration plus a 2-entry read response FIFO.
// Define RAM_DP_PORT_CTRL_CLEAR_EN to build in the zeroing sweep (after reset and on clear_start).
module ram_dp_port_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] wr_cmd_addr,
    input  logic [DATA_WIDTH-1:0] wr_cmd_data,
    input  logic                  wr_cmd_valid,
    output logic                  wr_cmd_ready,
    input  logic [ADDR_WIDTH-1:0] rd_cmd_addr,
    input  logic                  rd_cmd_valid,
    output logic                  rd_cmd_ready,
    output logic [DATA_WIDTH-1:0] rd_resp_data,
    output logic                  rd_resp_valid,
    input  logic                  rd_resp_ready,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout,
    input  logic                  clear_start,
    output logic                  busy
);

    logic                  in_flight;
    logic                  last_wr;
    logic [1:0]            count;
    logic [1:0]            occ;
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic                  push;
    logic                  pop;
    logic                  rd_elig;
    logic                  wr_gnt;
    logic                  rd_gnt;
    logic                  clr_gnt;
    logic [ADDR_WIDTH-1:0] clr_addr;
    logic [DATA_WIDTH-1:0] fifo_mem [2];

`ifdef RAM_DP_PORT_CTRL_CLEAR_EN
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    typedef enum logic {
        S_RUN,
        S_CLEAR
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [ADDR_WIDTH-1:0] clr_addr_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_CLEAR;
            clr_addr <= '0;
        end else begin
            state    <= state_nxt;
            clr_addr <= clr_addr_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        clr_addr_nxt = clr_addr;
        unique case (state)
            S_RUN: begin
                if (clear_start) begin
                    state_nxt    = S_CLEAR;
                    clr_addr_nxt = '0;
                end
            end
            S_CLEAR: begin
                clr_addr_nxt = clr_addr + ADDR_WIDTH'(1);
                if (clr_addr == LAST_ADDR) begin
                    state_nxt = S_RUN;
                end
            end
            default: state_nxt = S_RUN;
        endcase
    end

    assign busy    = (state == S_CLEAR);
    // The sweep must not write while reset holds the port idle.
    assign clr_gnt = busy & ~rst;
`else
    logic unused_clear_start;

    assign unused_clear_start = clear_start;
    assign busy               = 1'b0;
    assign clr_gnt            = 1'b0;
    assign clr_addr           = '0;
`endif

    assign rd_resp_valid = (count != 2'd0);
    assign rd_resp_data  = fifo_mem[rd_ptr];
    assign pop           = rd_resp_valid & rd_resp_ready;
    assign push          = in_flight;
    assign occ           = count + {1'b0, in_flight};
    // A slot freed by this cycle's pop can be reused by a new read.
    assign rd_elig       = rd_cmd_valid &
                           ((occ < 2'd2) | ((occ == 2'd2) & pop));

    always_comb begin
        wr_gnt = 1'b0;
        rd_gnt = 1'b0;
        if (!rst && !busy) begin
            if (wr_cmd_valid && rd_elig) begin
                if (last_wr) begin
                    rd_gnt = 1'b1;
                end else begin
                    wr_gnt = 1'b1;
                end
            end else if (wr_cmd_valid) begin
                wr_gnt = 1'b1;
            end else if (rd_elig) begin
                rd_gnt = 1'b1;
            end
        end
    end

    assign wr_cmd_ready = wr_gnt;
    assign rd_cmd_ready = rd_gnt;

    always_comb begin
        ram_we   = 1'b0;
        ram_addr = '0;
        ram_din  = '0;
        unique case (1'b1)
            clr_gnt: begin
                ram_we   = 1'b1;
                ram_addr = clr_addr;
            end
            wr_gnt: begin
                ram_we   = 1'b1;
                ram_addr = wr_cmd_addr;
                ram_din  = wr_cmd_data;
            end
            rd_gnt: begin
                ram_addr = rd_cmd_addr;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_flight <= 1'b0;
            last_wr   <= 1'b0;
            count     <= 2'd0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
        end else begin
            in_flight <= rd_gnt;
            if (wr_gnt || rd_gnt) begin
                last_wr <= wr_gnt;
            end
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= ram_dout;
        end
    end

endmodule

// File: tb/tb_ram_dp_port_ctrl.sv
// Bench for ram_dp_port_ctrl with a registered-read RAM model and a read scoreboard.
// Sweep checks are enabled when RAM_DP_PORT_CTRL_CLEAR_EN is defined.
module tb_ram_dp_port_ctrl;

    localparam int DW = 32;
    localparam int AW = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] wr_cmd_addr;
    logic [DW-1:0] wr_cmd_data;
    logic          wr_cmd_valid;
    logic          wr_cmd_ready;
    logic [AW-1:0] rd_cmd_addr;
    logic          rd_cmd_valid;
    logic          rd_cmd_ready;
    logic [DW-1:0] rd_resp_data;
    logic          rd_resp_valid;
    logic          rd_resp_ready;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;
    logic          clear_start;
    logic          busy;

    logic [DW-1:0] ram_mem [DEPTH];
    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] exp_q [$];

    int nvec = 0;
    int nerr = 0;
    int nresp = 0;

    ram_dp_port_ctrl #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_cmd_addr  (wr_cmd_addr),
        .wr_cmd_data  (wr_cmd_data),
        .wr_cmd_valid (wr_cmd_valid),
        .wr_cmd_ready (wr_cmd_ready),
        .rd_cmd_addr  (rd_cmd_addr),
        .rd_cmd_valid (rd_cmd_valid),
        .rd_cmd_ready (rd_cmd_ready),
        .rd_resp_data (rd_resp_data),
        .rd_resp_valid(rd_resp_valid),
        .rd_resp_ready(rd_resp_ready),
        .ram_we       (ram_we),
        .ram_addr     (ram_addr),
        .ram_din      (ram_din),
        .ram_dout     (ram_dout),
        .clear_start  (clear_start),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) begin
            ram_mem[ram_addr] <= ram_din;
        end
        ram_dout <= ram_mem[ram_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Scoreboard: expected data captured from the reference memory at read acceptance.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            if (wr_cmd_valid && wr_cmd_ready) begin
                ref_mem[wr_cmd_addr] = wr_cmd_data;
            end
            if (rd_cmd_valid && rd_cmd_ready) begin
                exp_q.push_back(ref_mem[rd_cmd_addr]);
            end
            if (rd_resp_valid && rd_resp_ready) begin
                nresp++;
                if (exp_q.size() == 0) begin
                    chk("resp_spurious", 32'd1, 32'd0);
                end else begin
                    chk("resp", rd_resp_data, exp_q.pop_front());
                end
            end
        end
    end

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("drain", exp_q.size(), 0);
    endtask

    task automatic zero_ref();
        for (int i = 0; i < DEPTH; i++) begin
            ref_mem[i] = '0;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  acc_n;
        int  guard;
        int  n;
        int  r0;
        int  wa;
        int  ra;
        bit  a;
        bit  aw;
        bit  ew;
        bit  found;

        for (int i = 0; i < DEPTH; i++) begin
            ram_mem[i] = 32'hA500_0000 | i;
            ref_mem[i] = 32'hA500_0000 | i;
        end
        ram_dout      = '0;
        rst           = 1'b1;
        clear_start   = 1'b0;
        rd_resp_ready = 1'b1;
        wr_cmd_valid  = 1'b1;
        wr_cmd_addr   = 4'd3;
        wr_cmd_data   = 32'hDEAD_BEEF;
        rd_cmd_valid  = 1'b1;
        rd_cmd_addr   = 4'd5;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_wr_ready", wr_cmd_ready, 0);
        chk("rst_rd_ready", rd_cmd_ready, 0);
        chk("rst_resp_valid", rd_resp_valid, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_ram_din", ram_din, 0);
`ifdef RAM_DP_PORT_CTRL_CLEAR_EN
        chk("rst_busy", busy, 1);
`else
        chk("rst_busy", busy, 0);
`endif

        @(posedge clk);
        #1;
        rst          = 1'b0;
        rd_cmd_valid = 1'b0;

`ifdef RAM_DP_PORT_CTRL_CLEAR_EN
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            chk("sweep_busy", busy, 1);
            chk("sweep_we", ram_we, 1);
            chk("sweep_din", ram_din, 0);
            chk("sweep_addr", ram_addr, i);
            chk("sweep_stall", wr_cmd_ready, 0);
            if (i == DEPTH - 1) begin
                zero_ref();
            end
        end
`endif
        @(negedge clk);
        chk("first_busy", busy, 0);
        chk("first_wr", wr_cmd_ready, 1);

        // Read-after-write latency
        @(posedge clk);
        #1;
        wr_cmd_valid = 1'b0;
        rd_cmd_valid = 1'b1;
        rd_cmd_addr  = 4'd3;
        @(negedge clk);
        chk("raw_rd_ready", rd_cmd_ready, 1);
        @(posedge clk);
        #1;
        rd_cmd_valid = 1'b0;
        @(negedge clk);
        chk("raw_valid_n2", rd_resp_valid, 0);
        @(negedge clk);
        chk("raw_valid_n3", rd_resp_valid, 1);
        chk("raw_data", rd_resp_data, 32'hDEAD_BEEF);

        // Both streams valid: strict alternation, write first
        @(posedge clk);
        #1;
        wa           = 0;
        ra           = 8;
        wr_cmd_valid = 1'b1;
        wr_cmd_addr  = AW'(wa);
        wr_cmd_data  = 32'hC0DE_0000 | wa;
        rd_cmd_valid = 1'b1;
        rd_cmd_addr  = AW'(ra);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            ew = (i % 2 == 0);
            chk("alt_wr", wr_cmd_ready, ew);
            chk("alt_rd", rd_cmd_ready, !ew);
            aw = wr_cmd_ready;
            a  = rd_cmd_ready;
            @(posedge clk);
            #1;
            if (aw) begin
                wa++;
                wr_cmd_addr = AW'(wa);
                wr_cmd_data = 32'hC0DE_0000 | wa;
            end
            if (a) begin
                ra++;
                rd_cmd_addr = AW'(ra);
            end
        end
        wr_cmd_valid = 1'b0;
        rd_cmd_valid = 1'b0;
        chk("alt_wcount", wa, 4);
        chk("alt_rcount", ra, 12);
        drain();

        // Back-pressure: only two reads fit
        @(posedge clk);
        #1;
        r0            = nresp;
        acc_n         = 0;
        rd_resp_ready = 1'b0;
        rd_cmd_valid  = 1'b1;
        rd_cmd_addr   = 4'd0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("bp_ready", rd_cmd_ready, (i < 2));
            a = rd_cmd_ready;
            @(posedge clk);
            #1;
            if (a) begin
                acc_n++;
                rd_cmd_addr = AW'(acc_n);
            end
        end
        rd_resp_ready = 1'b1;
        guard         = 0;
        while (acc_n < 6 && guard < 40) begin
            @(negedge clk);
            a = rd_cmd_ready;
            @(posedge clk);
            #1;
            if (a) begin
                acc_n++;
                rd_cmd_addr = AW'(acc_n);
            end
            if (acc_n == 6) begin
                rd_cmd_valid = 1'b0;
            end
            guard++;
        end
        rd_cmd_valid = 1'b0;
        chk("bp_accepted", acc_n, 6);
        drain();
        chk("bp_responses", nresp - r0, 6);

`ifdef RAM_DP_PORT_CTRL_CLEAR_EN
        // Clear with two reads outstanding
        @(posedge clk);
        #1;
        r0            = nresp;
        rd_resp_ready = 1'b0;
        rd_cmd_valid  = 1'b1;
        rd_cmd_addr   = 4'd0;
        @(negedge clk);
        chk("clr_rd0", rd_cmd_ready, 1);
        @(posedge clk);
        #1;
        rd_cmd_addr = 4'd1;
        @(negedge clk);
        chk("clr_rd1", rd_cmd_ready, 1);
        @(posedge clk);
        #1;
        rd_cmd_valid = 1'b0;
        clear_start  = 1'b1;
        @(posedge clk);
        #1;
        clear_start   = 1'b0;
        rd_resp_ready = 1'b1;
        n             = 0;
        guard         = 0;
        while (guard < 40) begin
            @(negedge clk);
            if (!busy) begin
                break;
            end
            n++;
            clear_start = (n == 5);
            if (n == DEPTH) begin
                zero_ref();
            end
            guard++;
        end
        clear_start = 1'b0;
        chk("clr_len", n, DEPTH);
        drain();
        chk("clr_responses", nresp - r0, 2);
        @(posedge clk);
        #1;
        rd_cmd_valid = 1'b1;
        rd_cmd_addr  = 4'd2;
        @(negedge clk);
        chk("clr_rd_after", rd_cmd_ready, 1);
        @(posedge clk);
        #1;
        rd_cmd_valid = 1'b0;
        drain();

        // Reset in the middle of a sweep
        @(posedge clk);
        #1;
        clear_start = 1'b1;
        @(posedge clk);
        #1;
        clear_start = 1'b0;
        found       = 0;
        guard       = 0;
        while (!found && guard < 40) begin
            @(negedge clk);
            if (busy && ram_addr == 4'd6) begin
                found = 1;
            end
            guard++;
        end
        chk("sweep_at7", found, 1);
        @(posedge clk);
        #1;
        chk("mid_addr", ram_addr, 7);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_we", ram_we, 0);
        @(posedge clk);
        #1;
        rst          = 1'b0;
        wr_cmd_valid = 1'b1;
        wr_cmd_addr  = 4'd6;
        wr_cmd_data  = 32'h600D_F00D;
        rd_cmd_valid = 1'b1;
        rd_cmd_addr  = 4'd9;
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            chk("resweep_busy", busy, 1);
            chk("resweep_addr", ram_addr, i);
            chk("resweep_stall", wr_cmd_ready | rd_cmd_ready, 0);
            if (i == DEPTH - 1) begin
                zero_ref();
            end
        end
`else
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst          = 1'b0;
        wr_cmd_valid = 1'b1;
        wr_cmd_addr  = 4'd6;
        wr_cmd_data  = 32'h600D_F00D;
        rd_cmd_valid = 1'b1;
        rd_cmd_addr  = 4'd9;
`endif
        @(negedge clk);
        chk("post_rst_wr", wr_cmd_ready, 1);
        chk("post_rst_rd", rd_cmd_ready, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("post_rst_wr2", wr_cmd_ready, 0);
        chk("post_rst_rd2", rd_cmd_ready, 1);
        @(posedge clk);
        #1;
        wr_cmd_valid = 1'b0;
        rd_cmd_valid = 1'b0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
